cnn_mac_pipe: RTL and testbench
===============================

// Module: cnn_mac_pipe
// PURPOSE
//   Pipelined signed multiply-accumulate for conv-layer kernels. Generalises the fixed 14s x 7s
//   combinational multiplier: parametrised widths, registered multiplier pipeline, NUM_TAPS-long
//   dot product seeded with a bias, round-to-nearest rescale and saturation to the output width.
//   Sits between the window/weight fetch logic and the activation/output buffer of each conv layer.
// PARAMETERS
//   DIN0_WIDTH  14  signed activation operand width
//   DIN1_WIDTH  7   signed weight operand width
//   ACC_WIDTH   32  accumulator and bias width (two's complement)
//   DOUT_WIDTH  16  signed result width after rescale
//   FRAC_SHIFT  6   arithmetic right shift applied to the final sum (0 = no shift, no rounding)
//   MUL_STAGES  2   register stages in the multiplier (>=1)
//   NUM_TAPS    9   products per result (9 = 3x3 kernel, >=1)
// PORTS
//   clk        in   1           clock
//   reset      in   1           asynchronous, active-high reset
//   ce         in   1           global clock enable; 0 freezes every register
//   in_valid   in   1           din0/din1 (and bias on tap 0) valid
//   in_ready   out  1           tap accepted when in_valid & in_ready
//   din0       in   DIN0_WIDTH  signed activation
//   din1       in   DIN1_WIDTH  signed weight
//   bias       in   ACC_WIDTH   signed bias, sampled only with tap 0 of each result
//   out_valid  out  1           dout/dout_sat valid
//   out_ready  in   1           result consumed when out_valid & out_ready
//   dout       out  DOUT_WIDTH  rounded, saturated result
//   dout_sat   out  1           1 if dout was clipped
// BEHAVIOUR
//   - Reset (async assert): out_valid=0, dout=0, dout_sat=0, tap counter=0, all pipe valid bits=0,
//     accumulator=0; partial sum in flight is discarded. in_ready=0 while reset is high.
//   - advance = ce & ~(out_valid & ~out_ready); in_ready = advance. Whole pipe stalls on advance=0.
//   - Tap counter 0..NUM_TAPS-1 increments per accepted tap, wraps to 0 after NUM_TAPS-1; first/last
//     flags travel with the operands through the pipe.
//   - Product: signed DIN0_WIDTH+DIN1_WIDTH bits, sign-extended to ACC_WIDTH; registered MUL_STAGES.
//   - Accumulate stage: first tap: acc = bias + prod; else acc = acc + prod; wraps mod 2^ACC_WIDTH.
//     Elaboration error if ACC_WIDTH < DIN0_WIDTH+DIN1_WIDTH+clog2(NUM_TAPS)+1.
//   - Output stage on last tap: r = (acc + 2^(FRAC_SHIFT-1)) >>> FRAC_SHIFT (ties round up toward
//     +inf); clip to [-2^(DOUT_WIDTH-1), 2^(DOUT_WIDTH-1)-1], dout_sat=1 when clipped; out_valid=1.
//   - Latency: last tap accepted in cycle 0 -> out_valid in cycle MUL_STAGES+2 with no stalls;
//     each cycle of advance=0 adds one. Throughput one tap/cycle; one result per NUM_TAPS taps.
//   - out_valid & out_ready & new result arriving same cycle: dout replaced, out_valid stays 1.
//   - dout/dout_sat hold value while out_valid & ~out_ready, and after consumption until replaced.
//   - ce=0: all state holds, including out_valid; a handshake cannot complete.
//   - in_valid=0 mid-result: counter and accumulator hold; gaps between taps allowed.
// STRUCTURE
//   - Package cnn_mac_pkg: prod_width() and clog2() functions, sat_max/sat_min limit functions,
//     round_shift() function used by output stage and testbench model.
//   - Sub-module cnn_mac_pipe_mul: MUL_STAGES-deep signed multiplier with enable (DSP48 inferable),
//     carrying valid/first/last sideband alongside the product.
//   - Top: handshake/stall, tap counter, accumulator, round/saturate output register.
// TESTING (default parameters unless stated)
//   1. 9 taps din0=100 din1=3 bias=0 -> acc 2700, dout=42, dout_sat=0, out_valid 4 cycles after tap 9.
//   2. 9 taps din0=-8192 din1=-64 -> dout=32767 sat=1; din0=-8192 din1=63 -> dout=-32768 sat=1.
//   3. din1=0 all taps, bias=-32 -> dout=0; bias=32 -> 1; bias=-33 -> -1 (rounding edges).
//   4. out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0, dout stable; release -> no taps lost.
//   5. Assert reset after 5 taps, then 9 fresh taps of 100x3 -> single result 42, no stale sum.
//   6. ce=0 for 3 cycles mid-result -> same dout as test 1, out_valid delayed by exactly 3 cycles.

Source files
------------

// File: rtl/cnn_mac_pkg.sv
// Shared types and arithmetic helpers for the conv-layer MAC pipeline.
// round_shift/sat_* are used by the output stage and mirror its rounding rule.
package cnn_mac_pkg;

    localparam int unsigned WideWidth = 64;

    typedef logic signed [WideWidth-1:0] wide_t;

    typedef struct packed {
        logic first;
        logic last;
    } tap_flags_t;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        longint unsigned span;
        res  = 0;
        span = 1;
        while (span < longint'(value)) begin
            span = span << 1;
            res  = res + 1;
        end
        return res;
    endfunction

    function automatic int unsigned prod_width(input int unsigned a_width,
                                               input int unsigned b_width);
        return a_width + b_width;
    endfunction

    function automatic wide_t sat_max(input int unsigned width);
        return (wide_t'(1) <<< (width - 1)) - wide_t'(1);
    endfunction

    function automatic wide_t sat_min(input int unsigned width);
        return -(wide_t'(1) <<< (width - 1));
    endfunction

    // Round half toward +inf, then arithmetic shift; shift of 0 is a pass-through.
    function automatic wide_t round_shift(input wide_t value, input int unsigned shift);
        wide_t half;
        if (shift == 0) begin
            return value;
        end
        half = wide_t'(1) <<< (shift - 1);
        return (value + half) >>> shift;
    endfunction

endpackage

// File: rtl/cnn_mac_pipe_mul.sv
// STAGES-deep signed multiplier with a shared enable; valid and an opaque sideband
// vector travel in lock-step with the product. Data regs are reset-free for DSP packing.
module cnn_mac_pipe_mul
    import cnn_mac_pkg::*;
#(
    parameter int unsigned A_WIDTH    = 14,
    parameter int unsigned B_WIDTH    = 7,
    parameter int unsigned STAGES     = 2,
    parameter int unsigned SIDE_WIDTH = 34
) (
    input  logic                                         clk_i,
    input  logic                                         rst_i,
    input  logic                                         en_i,
    input  logic                                         valid_i,
    input  logic signed [A_WIDTH-1:0]                    a_i,
    input  logic signed [B_WIDTH-1:0]                    b_i,
    input  logic        [SIDE_WIDTH-1:0]                 side_i,
    output logic                                         valid_o,
    output logic signed [prod_width(A_WIDTH, B_WIDTH)-1:0] prod_o,
    output logic        [SIDE_WIDTH-1:0]                 side_o
);

    localparam int unsigned ProdWidth = prod_width(A_WIDTH, B_WIDTH);

    logic signed [ProdWidth-1:0]  mul_c;
    logic signed [ProdWidth-1:0]  prod_q [STAGES];
    logic        [SIDE_WIDTH-1:0] side_q [STAGES];
    logic        [STAGES-1:0]     valid_q;

    assign mul_c = ProdWidth'(a_i) * ProdWidth'(b_i);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= '0;
        end else if (en_i) begin
            valid_q[0] <= valid_i;
            for (int unsigned s = 1; s < STAGES; s++) begin
                valid_q[s] <= valid_q[s-1];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (en_i) begin
            prod_q[0] <= mul_c;
            side_q[0] <= side_i;
            for (int unsigned s = 1; s < STAGES; s++) begin
                prod_q[s] <= prod_q[s-1];
                side_q[s] <= side_q[s-1];
            end
        end
    end

    assign valid_o = valid_q[STAGES-1];
    assign prod_o  = prod_q[STAGES-1];
    assign side_o  = side_q[STAGES-1];

endmodule

// File: rtl/cnn_mac_pipe.sv
// Pipelined signed MAC: NUM_TAPS products summed onto a bias, rounded, rescaled and
// saturated to DOUT_WIDTH. A single advance signal stalls the whole pipe.
module cnn_mac_pipe
    import cnn_mac_pkg::*;
#(
    parameter int unsigned DIN0_WIDTH = 14,
    parameter int unsigned DIN1_WIDTH = 7,
    parameter int unsigned ACC_WIDTH  = 32,
    parameter int unsigned DOUT_WIDTH = 16,
    parameter int unsigned FRAC_SHIFT = 6,
    parameter int unsigned MUL_STAGES = 2,
    parameter int unsigned NUM_TAPS   = 9
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         ce_i,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  logic signed [DIN0_WIDTH-1:0] din0_i,
    input  logic signed [DIN1_WIDTH-1:0] din1_i,
    input  logic signed [ACC_WIDTH-1:0]  bias_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic signed [DOUT_WIDTH-1:0] dout_o,
    output logic                         dout_sat_o
);

    localparam int unsigned ProdWidth = prod_width(DIN0_WIDTH, DIN1_WIDTH);
    localparam int unsigned CntWidth  = (NUM_TAPS > 1) ? clog2(NUM_TAPS) : 1;
    localparam int unsigned SideWidth = ACC_WIDTH + $bits(tap_flags_t);
    localparam logic [CntWidth-1:0] LastTap = CntWidth'(NUM_TAPS - 1);

    if (ACC_WIDTH < ProdWidth + clog2(NUM_TAPS) + 1) begin : gen_acc_width_check
        $error("ACC_WIDTH too narrow to hold NUM_TAPS products without overflow");
    end
    if (MUL_STAGES < 1 || NUM_TAPS < 1 || ACC_WIDTH > WideWidth) begin : gen_param_check
        $error("MUL_STAGES and NUM_TAPS must be >= 1 and ACC_WIDTH <= 64");
    end

    logic                        advance;
    logic                        accept;
    logic [CntWidth-1:0]         tap_cnt_q, tap_cnt_d;
    tap_flags_t                  in_flags, mul_flags;
    logic                        mul_valid;
    logic signed [ProdWidth-1:0] mul_prod;
    logic [SideWidth-1:0]        mul_side;
    logic signed [ACC_WIDTH-1:0] mul_bias;
    logic signed [ACC_WIDTH-1:0] prod_ext;

    logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
    logic                         acc_valid_q, acc_valid_d;
    logic                         acc_last_q, acc_last_d;
    logic                         out_valid_q, out_valid_d;
    logic signed [DOUT_WIDTH-1:0] dout_q, dout_d;
    logic                         dout_sat_q, dout_sat_d;
    wide_t                        rounded, clipped;
    logic                         clip;

    // A held, unconsumed result blocks the pipe so nothing in flight can be lost.
    assign advance    = ce_i & ~(out_valid_q & ~out_ready_i);
    assign in_ready_o = advance & ~rst_i;
    assign accept     = in_valid_i & in_ready_o;

    assign in_flags.first = (tap_cnt_q == '0);
    assign in_flags.last  = (tap_cnt_q == LastTap);
    assign tap_cnt_d      = !accept       ? tap_cnt_q :
                            in_flags.last ? '0        : tap_cnt_q + 1'b1;

    cnn_mac_pipe_mul #(
        .A_WIDTH    (DIN0_WIDTH),
        .B_WIDTH    (DIN1_WIDTH),
        .STAGES     (MUL_STAGES),
        .SIDE_WIDTH (SideWidth)
    ) u_mul (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .en_i    (advance),
        .valid_i (accept),
        .a_i     (din0_i),
        .b_i     (din1_i),
        .side_i  ({bias_i, in_flags}),
        .valid_o (mul_valid),
        .prod_o  (mul_prod),
        .side_o  (mul_side)
    );

    assign {mul_bias, mul_flags} = mul_side;
    assign prod_ext              = ACC_WIDTH'(mul_prod);

    always_comb begin
        acc_d       = acc_q;
        acc_valid_d = acc_valid_q;
        acc_last_d  = acc_last_q;
        if (advance) begin
            acc_valid_d = mul_valid;
            acc_last_d  = mul_flags.last;
            if (mul_valid) begin
                acc_d = (mul_flags.first ? mul_bias : acc_q) + prod_ext;
            end
        end
    end

    always_comb begin
        rounded = round_shift(WideWidth'(acc_q), FRAC_SHIFT);
        clipped = rounded;
        clip    = 1'b0;
        if (rounded > sat_max(DOUT_WIDTH)) begin
            clipped = sat_max(DOUT_WIDTH);
            clip    = 1'b1;
        end else if (rounded < sat_min(DOUT_WIDTH)) begin
            clipped = sat_min(DOUT_WIDTH);
            clip    = 1'b1;
        end

        out_valid_d = out_valid_q;
        dout_d      = dout_q;
        dout_sat_d  = dout_sat_q;
        if (advance) begin
            out_valid_d = acc_valid_q & acc_last_q;
            if (acc_valid_q & acc_last_q) begin
                dout_d     = DOUT_WIDTH'(clipped);
                dout_sat_d = clip;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tap_cnt_q   <= '0;
            acc_q       <= '0;
            acc_valid_q <= 1'b0;
            acc_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
            dout_q      <= '0;
            dout_sat_q  <= 1'b0;
        end else begin
            tap_cnt_q   <= tap_cnt_d;
            acc_q       <= acc_d;
            acc_valid_q <= acc_valid_d;
            acc_last_q  <= acc_last_d;
            out_valid_q <= out_valid_d;
            dout_q      <= dout_d;
            dout_sat_q  <= dout_sat_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign dout_o      = dout_q;
    assign dout_sat_o  = dout_sat_q;

endmodule

// File: tb/tb_cnn_mac_pipe.sv
// Directed bench for cnn_mac_pipe at default parameters; expected values are hand-computed.
module tb_cnn_mac_pipe;

    localparam int MulStages = 2;
    localparam int Latency   = MulStages + 2;

    logic               clk = 1'b0;
    logic               rst;
    logic               ce;
    logic               in_valid;
    logic               in_ready;
    logic signed [13:0] din0;
    logic signed [6:0]  din1;
    logic signed [31:0] bias;
    logic               out_valid;
    logic               out_ready;
    logic signed [15:0] dout;
    logic               dout_sat;

    int n_vec = 0;
    int n_err = 0;
    int lat;
    int bias3 [3] = '{-32, 32, -33};
    int exp3  [3] = '{0, 1, -1};

    always #5 clk = ~clk;

    cnn_mac_pipe #(
        .DIN0_WIDTH (14),
        .DIN1_WIDTH (7),
        .ACC_WIDTH  (32),
        .DOUT_WIDTH (16),
        .FRAC_SHIFT (6),
        .MUL_STAGES (MulStages),
        .NUM_TAPS   (9)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .ce_i        (ce),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .din0_i      (din0),
        .din1_i      (din1),
        .bias_i      (bias),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .dout_o      (dout),
        .dout_sat_o  (dout_sat)
    );

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_taps(input int n, input int a, input int b, input int bs);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            din0     = 14'(a);
            din1     = 7'(b);
            bias     = 32'(bs);
            if (in_ready !== 1'b1) begin
                check("tap_ready", 64'(in_ready), 1);
            end
            tick();
        end
        in_valid = 1'b0;
    endtask

    // Edges counted from the last accepted tap; reported as cycle index of out_valid.
    task automatic wait_out(input int start, output int cycles);
        cycles = start;
        while (out_valid !== 1'b1 && cycles < 30) begin
            tick();
            cycles++;
        end
        cycles = cycles + 1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        ce        = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        din0      = '0;
        din1      = '0;
        bias      = '0;
        #12;
        check("rst_out_valid", 64'(out_valid), 0);
        check("rst_dout", dout, 0);
        check("rst_sat", 64'(dout_sat), 0);
        check("rst_in_ready", 64'(in_ready), 0);
        tick();
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 64'(in_ready), 1);

        // 1: basic dot product and latency
        send_taps(9, 100, 3, 0);
        wait_out(0, lat);
        check("t1_latency", lat, Latency);
        check("t1_dout", dout, 42);
        check("t1_sat", 64'(dout_sat), 0);
        tick();
        check("t1_consumed", 64'(out_valid), 0);
        check("t1_dout_hold", dout, 42);

        // 2: saturation both ways
        send_taps(9, -8192, -64, 0);
        wait_out(0, lat);
        check("t2_pos_dout", dout, 32767);
        check("t2_pos_sat", 64'(dout_sat), 1);
        tick();
        send_taps(9, -8192, 63, 0);
        wait_out(0, lat);
        check("t2_neg_dout", dout, -32768);
        check("t2_neg_sat", 64'(dout_sat), 1);
        tick();

        // 3: rounding edges from bias alone
        for (int i = 0; i < 3; i++) begin
            send_taps(9, 1234, 0, bias3[i]);
            wait_out(0, lat);
            check("t3_round", dout, exp3[i]);
            check("t3_sat", 64'(dout_sat), 0);
            tick();
        end

        // 4: output back-pressure stalls input without losing taps
        out_ready = 1'b0;
        send_taps(9, 100, 3, 0);
        wait_out(0, lat);
        check("t4_first_dout", dout, 42);
        in_valid = 1'b1;
        din0     = 14'(50);
        din1     = -7'sd2;
        bias     = 32'(6400);
        for (int i = 0; i < 5; i++) begin
            check("t4_stall_ready", 64'(in_ready), 0);
            check("t4_stall_valid", 64'(out_valid), 1);
            check("t4_stall_dout", dout, 42);
            tick();
        end
        out_ready = 1'b1;
        #1;
        send_taps(9, 50, -2, 6400);
        wait_out(0, lat);
        check("t4_second_latency", lat, Latency);
        check("t4_second_dout", dout, 86);
        tick();

        // 5: reset mid-result discards the partial sum
        send_taps(5, 100, 3, 999);
        rst = 1'b1;
        #1;
        check("t5_rst_dout", dout, 0);
        check("t5_rst_in_ready", 64'(in_ready), 0);
        tick();
        rst = 1'b0;
        #1;
        send_taps(9, 100, 3, 0);
        wait_out(0, lat);
        check("t5_latency", lat, Latency);
        check("t5_dout", dout, 42);
        tick();
        repeat (4) tick();
        check("t5_no_extra", 64'(out_valid), 0);

        // 6: ce low while the result is in flight delays it cycle for cycle
        send_taps(9, 100, 3, 0);
        ce = 1'b0;
        #1;
        check("t6_ce_in_ready", 64'(in_ready), 0);
        repeat (3) tick();
        ce = 1'b1;
        wait_out(3, lat);
        check("t6_latency", lat, Latency + 3);
        check("t6_dout", dout, 42);
        ce = 1'b0;
        tick();
        check("t6_ce_hold_valid", 64'(out_valid), 1);
        ce = 1'b1;
        tick();
        check("t6_consumed", 64'(out_valid), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
